// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue block and the ALU itself.
//   state_t          : issue FSM state encoding
//   CLR_CMP..SIGN_ON : instruction codes 0xB9..0xBF understood by the ALU
//   is_mode()        : true for mode-setting instructions (0xBA..0xBF), which
//                      the ALU absorbs without a start/done cycle
package alu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE,
    MODE_SETTLE,
    RESP
  } state_t;

  localparam logic [9:0] CLR_CMP   = 10'h0B9;
  localparam logic [9:0] FLAGS_OFF = 10'h0BA;
  localparam logic [9:0] FLAGS_ON  = 10'h0BB;
  localparam logic [9:0] CARRY_OFF = 10'h0BC;
  localparam logic [9:0] CARRY_ON  = 10'h0BD;
  localparam logic [9:0] SIGN_OFF  = 10'h0BE;
  localparam logic [9:0] SIGN_ON   = 10'h0BF;

  function automatic logic is_mode(input logic [9:0] ir);
    return ir inside {FLAGS_OFF, FLAGS_ON, CARRY_OFF, CARRY_ON, SIGN_OFF, SIGN_ON};
  endfunction

endpackage

// File: rtl/alu_issue.sv
// Issues one instruction at a time to an external ALU and returns its result.
//   clk, rst_n            : clock, asynchronous active-low reset
//   req_valid/req_ready   : request handshake carrying req_ir, req_a, req_b, req_carry
//   rsp_valid/rsp_ready   : response handshake carrying rsp_result and flags
//                           (rsp_carry, rsp_over, rsp_zero, rsp_neg, rsp_cmp, rsp_err)
//   alu_start, alu_ir, alu_a, alu_b, alu_carryin, alu_oe : ALU drive
//   alu_done, alu_out, alu_carryout, alu_overout, alu_cmpo : ALU results
// An op that does not complete within TIMEOUT_CYCLES is aborted with rsp_err.
module alu_issue
  import alu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [9:0]  req_ir,
  input  logic [15:0] req_a,
  input  logic [15:0] req_b,
  input  logic        req_carry,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_result,
  output logic        rsp_carry,
  output logic        rsp_over,
  output logic        rsp_zero,
  output logic        rsp_neg,
  output logic        rsp_cmp,
  output logic        rsp_err,
  output logic        alu_start,
  output logic [9:0]  alu_ir,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic        alu_carryin,
  output logic        alu_oe,
  input  logic        alu_done,
  input  logic [15:0] alu_out,
  input  logic        alu_carryout,
  input  logic        alu_overout,
  input  logic        alu_cmpo
);

  localparam logic [5:0] TO_LIM = 6'(TIMEOUT_CYCLES);

  state_t      state_q, state_d;
  logic [9:0]  ir_q, ir_d;
  logic [15:0] a_q, a_d, b_q, b_d;
  logic        cin_q, cin_d;
  logic [15:0] res_q, res_d;
  logic        c_q, c_d, o_q, o_d, cmp_q, cmp_d, err_q, err_d;
  logic        cap_q, cap_d;   // result came from the ALU (gates rsp_zero)
  logic [5:0]  cnt_q, cnt_d;
  logic        drive;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ir_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cin_q   <= 1'b0;
      res_q   <= '0;
      c_q     <= 1'b0;
      o_q     <= 1'b0;
      cmp_q   <= 1'b0;
      err_q   <= 1'b0;
      cap_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cin_q   <= cin_d;
      res_q   <= res_d;
      c_q     <= c_d;
      o_q     <= o_d;
      cmp_q   <= cmp_d;
      err_q   <= err_d;
      cap_q   <= cap_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    a_d     = a_q;
    b_d     = b_q;
    cin_d   = cin_q;
    res_d   = res_q;
    c_d     = c_q;
    o_d     = o_q;
    cmp_d   = cmp_q;
    err_d   = err_q;
    cap_d   = cap_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          ir_d    = req_ir;
          a_d     = req_a;
          b_d     = req_b;
          cin_d   = req_carry;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        res_d   = '0;
        c_d     = 1'b0;
        o_d     = 1'b0;
        cmp_d   = 1'b0;
        err_d   = 1'b0;
        cap_d   = 1'b0;
        state_d = is_mode(ir_q) ? MODE_SETTLE : WAIT_BUSY;
      end
      WAIT_BUSY, WAIT_DONE: begin
        cmp_d = cmp_q | alu_cmpo;
        cnt_d = cnt_q + 6'd1;
        // Timeout wins over a completion seen in the same cycle.
        if (cnt_q == TO_LIM) begin
          err_d   = 1'b1;
          cmp_d   = 1'b0;
          state_d = RESP;
        end else if (state_q == WAIT_BUSY) begin
          if (!alu_done) state_d = WAIT_DONE;
        end else if (alu_done) begin
          res_d   = alu_out;
          c_d     = alu_carryout;
          o_d     = alu_overout;
          cap_d   = 1'b1;
          state_d = RESP;
        end
      end
      MODE_SETTLE: state_d = RESP;
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign drive       = (state_q == ISSUE) || (state_q == WAIT_BUSY) || (state_q == WAIT_DONE);
  assign req_ready   = (state_q == IDLE) && alu_done;
  assign alu_start   = (state_q == ISSUE) && !is_mode(ir_q);
  assign alu_oe      = (state_q == WAIT_DONE);
  assign alu_ir      = drive ? ir_q  : '0;
  assign alu_a       = drive ? a_q   : '0;
  assign alu_b       = drive ? b_q   : '0;
  assign alu_carryin = drive ? cin_q : 1'b0;

  assign rsp_valid  = (state_q == RESP);
  assign rsp_result = res_q;
  assign rsp_carry  = c_q;
  assign rsp_over   = o_q;
  assign rsp_zero   = cap_q && (res_q == '0);
  assign rsp_neg    = res_q[15];
  assign rsp_cmp    = cmp_q;
  assign rsp_err    = err_q;

endmodule

// File: tb/tb_alu_issue.sv
// Scoreboard bench for alu_issue: directed vectors push expectations, a monitor
// compares each response (values, latency, start pulses, operand drive, stability).
module tb_alu_issue;
  import alu_pkg::*;

  logic        clk, rst_n;
  logic        req_valid, req_ready, req_carry;
  logic [9:0]  req_ir;
  logic [15:0] req_a, req_b;
  logic        rsp_valid, rsp_ready;
  logic [15:0] rsp_result;
  logic        rsp_carry, rsp_over, rsp_zero, rsp_neg, rsp_cmp, rsp_err;
  logic        alu_start, alu_carryin, alu_oe;
  logic [9:0]  alu_ir;
  logic [15:0] alu_a, alu_b;
  logic        alu_done, alu_carryout, alu_overout, alu_cmpo;
  logic [15:0] alu_out;

  alu_issue #(.TIMEOUT_CYCLES(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_ir(req_ir),
    .req_a(req_a), .req_b(req_b), .req_carry(req_carry),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_carry(rsp_carry), .rsp_over(rsp_over), .rsp_zero(rsp_zero),
    .rsp_neg(rsp_neg), .rsp_cmp(rsp_cmp), .rsp_err(rsp_err),
    .alu_start(alu_start), .alu_ir(alu_ir), .alu_a(alu_a), .alu_b(alu_b),
    .alu_carryin(alu_carryin), .alu_oe(alu_oe),
    .alu_done(alu_done), .alu_out(alu_out), .alu_carryout(alu_carryout),
    .alu_overout(alu_overout), .alu_cmpo(alu_cmpo)
  );

  typedef struct {
    logic [9:0]  ir;
    logic [15:0] a, b;
    logic        cin;
    logic [15:0] mres;
    logic        mc, mo, mcmp, mhang;
    logic [15:0] eres;
    logic        ec, eo, ez, en, ecmp, eerr;
    int          elat, estarts, eirc;
  } vec_t;

  vec_t exp_q[$];
  vec_t mq[$];
  vec_t cur;
  int   n_cmp = 0, n_bad = 0;
  int   cyc = 0;
  logic [7:0] mcnt;
  logic m_kick;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(logic [9:0] ir, logic [15:0] a, logic [15:0] b, logic cin,
                              logic [15:0] mres, logic mc, logic mo, logic mcmp, logic mhang,
                              logic [15:0] eres, logic ec, logic eo, logic ez, logic en,
                              logic ecmp, logic eerr, int elat, int estarts, int eirc);
    vec_t v;
    v.ir = ir; v.a = a; v.b = b; v.cin = cin;
    v.mres = mres; v.mc = mc; v.mo = mo; v.mcmp = mcmp; v.mhang = mhang;
    v.eres = eres; v.ec = ec; v.eo = eo; v.ez = ez; v.en = en; v.ecmp = ecmp; v.eerr = eerr;
    v.elat = elat; v.estarts = estarts; v.eirc = eirc;
    return v;
  endfunction

  // ALU model: done drops one cycle after start, rises 7 cycles after start.
  assign alu_out      = cur.mres;
  assign alu_carryout = cur.mc;
  assign alu_overout  = cur.mo;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_done <= 1'b1;
      mcnt     <= '0;
      alu_cmpo <= 1'b0;
    end else begin
      alu_cmpo <= 1'b0;
      if (m_kick) begin
        alu_done <= 1'b1;
        mcnt     <= '0;
      end else if (alu_start) begin
        alu_done <= 1'b0;
        mcnt     <= 8'd1;
        if (mq.size() > 0) cur <= mq.pop_front();
      end else if (mcnt != 0) begin
        mcnt <= mcnt + 8'd1;
        if (cur.mcmp && mcnt == 8'd3) alu_cmpo <= 1'b1;
        if (!cur.mhang && mcnt == 8'd6) begin
          alu_done <= 1'b1;
          mcnt     <= '0;
        end
      end
    end
  end

  // Monitor
  int   acc = 0, hs_edge = 0, st_cnt = 0, ir_cnt = 0;
  logic in_rsp = 1'b0, unstable = 1'b0, b2b_chk = 1'b0;
  logic [21:0] snap;
  logic [42:0] s_ops;
  vec_t e;
  wire  [21:0] rsp_vec = {rsp_result, rsp_carry, rsp_over, rsp_zero, rsp_neg, rsp_cmp, rsp_err};

  always @(negedge clk) begin
    if (!rst_n) begin
      in_rsp = 1'b0; st_cnt = 0; ir_cnt = 0;
    end else begin
      if (req_valid && req_ready) begin
        acc = cyc + 1; st_cnt = 0; ir_cnt = 0;
        if (b2b_chk) begin
          chk("b2b_gap", 64'(acc - hs_edge), 64'd1);
          b2b_chk = 1'b0;
        end
      end
      if (alu_start) begin
        st_cnt++;
        s_ops = {alu_ir, alu_a, alu_b, alu_carryin};
      end
      if (alu_ir != '0) ir_cnt++;
      if (rsp_valid) begin
        if (!in_rsp) begin
          in_rsp = 1'b1;
          unstable = req_ready;
          snap = rsp_vec;
          if (exp_q.size() == 0) chk("spurious_rsp", 64'(rsp_valid), 64'd0);
          else begin
            e = exp_q.pop_front();
            chk("rsp", 64'(rsp_vec), 64'({e.eres, e.ec, e.eo, e.ez, e.en, e.ecmp, e.eerr}));
            chk("latency", 64'(cyc + 1 - acc), 64'(e.elat));
            chk("start_cycles", 64'(st_cnt), 64'(e.estarts));
            if (e.eirc >= 0) chk("alu_ir_cycles", 64'(ir_cnt), 64'(e.eirc));
            if (e.estarts == 1) chk("alu_operands", 64'(s_ops), 64'({e.ir, e.a, e.b, e.cin}));
          end
        end else if (rsp_vec != snap || req_ready) unstable = 1'b1;
        if (rsp_ready) begin
          chk("rsp_stable", 64'(unstable), 64'd0);
          in_rsp = 1'b0;
          hs_edge = cyc + 1;
        end
      end
    end
  end

  task automatic issue(input vec_t v);
    bit ok;
    exp_q.push_back(v);
    if (!is_mode(v.ir)) mq.push_back(v);
    @(negedge clk);
    req_valid = 1'b1; req_ir = v.ir; req_a = v.a; req_b = v.b; req_carry = v.cin;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (req_ready) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (!ok) chk("req_accept", 64'(ok), 64'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_rsp();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !rsp_valid) begin ok = 1'b1; break; end
    end
    chk("rsp_wait", 64'(ok), 64'd1);
  endtask

  task automatic chk_zero(input string nm);
    chk(nm, 64'({rsp_valid, rsp_vec, alu_start, alu_oe, alu_ir, alu_a, alu_b, alu_carryin}), 64'd0);
  endtask

  vec_t vt[$];

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_ir = '0; req_a = '0; req_b = '0; req_carry = 1'b0;
    rsp_ready = 1'b1; m_kick = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero("reset_outputs");
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", 64'(req_ready), 64'd1);

    vt.push_back(mk(10'h001, 16'h1234, 16'h0001, 1'b0, 16'h1235, 0, 0, 0, 0, 16'h1235, 0, 0, 0, 0, 0, 0, 9, 1, 8));
    vt.push_back(mk(10'h002, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1, 0, 1, 0, 16'h0000, 1, 0, 1, 0, 1, 0, 9, 1, 8));
    vt.push_back(mk(10'h003, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 0, 1, 0, 0, 16'h8000, 0, 1, 0, 1, 0, 0, 9, 1, 8));
    vt.push_back(mk(FLAGS_ON, 16'hAAAA, 16'h5555, 1'b1, 16'hDEAD, 1, 1, 1, 0, 16'h0000, 0, 0, 0, 0, 0, 0, 3, 0, 1));
    vt.push_back(mk(CLR_CMP, 16'h00F0, 16'h000F, 1'b1, 16'h00FF, 0, 0, 0, 0, 16'h00FF, 0, 0, 0, 0, 0, 0, 9, 1, 8));
    vt.push_back(mk(SIGN_ON, 16'h0001, 16'h0002, 1'b0, 16'h1111, 1, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 0, 0, 3, 0, 1));
    foreach (vt[i]) begin
      issue(vt[i]);
      wait_rsp();
    end

    // Hung ALU: aborted after 32 wait cycles, cmp pulse discarded.
    issue(mk(10'h004, 16'h0102, 16'h0304, 1'b1, 16'hBEEF, 1, 1, 1, 1, 16'h0000, 0, 0, 0, 0, 0, 1, 35, 1, 34));
    wait_rsp();
    m_kick = 1'b1;
    @(negedge clk);
    m_kick = 1'b0;
    issue(mk(10'h005, 16'h0040, 16'h0002, 1'b0, 16'h0042, 0, 0, 0, 0, 16'h0042, 0, 0, 0, 0, 0, 0, 9, 1, 8));
    wait_rsp();

    // Response held off for 5 cycles.
    rsp_ready = 1'b0;
    issue(mk(10'h006, 16'h8000, 16'h0001, 1'b1, 16'h8001, 1, 0, 1, 0, 16'h8001, 1, 0, 0, 1, 1, 0, 9, 1, 8));
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (rsp_valid) break;
    end
    repeat (5) @(negedge clk);
    rsp_ready = 1'b1;
    wait_rsp();

    // Back-to-back: second request waits with req_valid high.
    issue(mk(10'h007, 16'h0003, 16'h0003, 1'b0, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 0, 1, 0, 0, 0, 9, 1, 8));
    b2b_chk = 1'b1;
    issue(mk(10'h008, 16'h7FFE, 16'h0001, 1'b0, 16'h7FFF, 0, 1, 0, 0, 16'h7FFF, 0, 1, 0, 0, 0, 0, 9, 1, 8));
    wait_rsp();
    chk("b2b_checked", 64'(b2b_chk), 64'd0);

    // Reset while waiting for done: op discarded, no response.
    issue(mk(10'h009, 16'h1111, 16'h2222, 1'b1, 16'h3333, 1, 1, 1, 0, 16'h3333, 1, 1, 0, 0, 1, 0, 9, 1, 8));
    for (int i = 0; i < 20; i++) begin
      if (alu_oe) break;
      @(negedge clk);
    end
    chk("reached_wait_done", 64'(alu_oe), 64'd1);
    rst_n = 1'b0;
    #1;
    chk_zero("async_reset_outputs");
    exp_q.delete();
    mq.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("ready_after_midop_reset", 64'(req_ready), 64'd1);
    issue(mk(10'h00A, 16'h0100, 16'h0200, 1'b0, 16'h0300, 0, 0, 0, 0, 16'h0300, 0, 0, 0, 0, 0, 0, 9, 1, 8));
    wait_rsp();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 32, max cycles allowed between alu_start and the captured completion before the op is aborted.
REQ-002 Port: clk  input  1  single clock; every register updates on posedge clk.
REQ-003 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port: req_valid / req_ready  input / output  1 / 1  request handshake; a transfer occurs when both are high on a clock edge.
REQ-005 Port: req_ir  input  10  ALU instruction; req_a, req_b  input  16 each  operands; req_carry  input  1  carry-in.
REQ-006 Port: rsp_valid / rsp_ready  output / input  1 / 1  response handshake.
REQ-007 Port: rsp_result  output  16; rsp_carry, rsp_over, rsp_zero, rsp_neg, rsp_cmp, rsp_err  output  1 each  captured result and flags.
REQ-008 Port: alu_start  output  1; alu_ir  output  10; alu_a, alu_b  output  16; alu_carryin, alu_oe  output  1  drive the ALU.
REQ-009 Port: alu_done  input  1; alu_out  input  16; alu_carryout, alu_overout, alu_cmpo  input  1  ALU results.

Function
REQ-010 FSM states SHALL be exactly IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, MODE_SETTLE, RESP.
REQ-011 req_ready SHALL be high only in IDLE with alu_done=1; on acceptance, ir/a/b/carry are registered and the FSM enters ISSUE.
REQ-012 In ISSUE, the registered ir, a, b and carry SHALL drive alu_ir/alu_a/alu_b/alu_carryin and stay stable until RESP; outside ISSUE..WAIT_DONE, alu_ir=0, alu_a=alu_b=0, alu_carryin=0.
REQ-013 For a mode instruction (ir 0xBA..0xBF), ISSUE SHALL hold alu_start=0 for one cycle, then the FSM enters MODE_SETTLE for exactly one cycle, then RESP with result 0, flags 0, rsp_err=0.
REQ-014 For any other ir, alu_start SHALL be high for exactly the single ISSUE cycle, then the FSM enters WAIT_BUSY.
REQ-015 WAIT_BUSY SHALL exit to WAIT_DONE on the first cycle alu_done=0.
REQ-016 WAIT_DONE SHALL drive alu_oe=1 and, on the first cycle alu_done=1, capture alu_out, alu_carryout and alu_overout, then enter RESP.
REQ-017 rsp_cmp SHALL be a sticky OR of alu_cmpo over all WAIT_BUSY and WAIT_DONE cycles of the current op.
REQ-018 rsp_zero = (captured result == 0); rsp_neg = captured result bit 15; both are computed from the registered result.
REQ-019 A 6-bit cycle counter SHALL start at 0 in ISSUE and increment in WAIT_BUSY/WAIT_DONE; reaching TIMEOUT_CYCLES SHALL force RESP with rsp_err=1, result 0 and all flags 0.
REQ-020 rsp_valid SHALL be high only in RESP, with all rsp_* outputs stable until rsp_ready; on handshake, the FSM returns to IDLE.
REQ-021 Nominal latency (ALU done low 1 cycle after start, high 7 cycles after start) SHALL be accept edge -> rsp_valid 9 cycles later; a mode instruction SHALL give rsp_valid 3 cycles after accept.
REQ-022 A request cannot be accepted in the same cycle the response handshake completes (req_ready is low in RESP).

Reset
REQ-023 rst_n low SHALL immediately force IDLE, all counters and captured registers to 0, alu_start=0, alu_oe=0, rsp_valid=0 and all rsp_* outputs to 0.
REQ-024 Reset mid-operation SHALL discard the op without producing any response; req_ready is re-evaluated from alu_done after release.

Structure
REQ-025 Package alu_pkg SHALL hold the state_t typedef and the instruction constants 0xB9..0xBF (CLR_CMP, FLAGS_OFF/ON, CARRY_OFF/ON, SIGN_OFF/ON), shared with the ALU.
REQ-026 No sub-module SHALL be used; the block is a single FSM plus capture registers.

Verification
REQ-027 ALU model, ir=0x001, a=0x1234, b=0x0001, model result 0x1235, carry 0 -> rsp_result=0x1235, zero=0, neg=0, alu_start high for 1 cycle, rsp_valid 9 cycles after accept.
REQ-028 Model result 0x0000 with carryout=1 and a cmpo pulse -> rsp_zero=1, rsp_carry=1, rsp_cmp=1; model result 0x8000 -> rsp_neg=1.
REQ-029 ir=0xBB -> no alu_start pulse, alu_ir=0xBB for one cycle, rsp_valid after 3 cycles, result 0.
REQ-030 Model that never raises alu_done -> rsp_err=1 after TIMEOUT_CYCLES=32, then IDLE and normal operation on the next request.
REQ-031 Hold rsp_ready low for 5 cycles -> rsp_* stable and req_ready=0 throughout; back-to-back requests are accepted in the first IDLE cycle.
REQ-032 Drop rst_n in WAIT_DONE -> outputs zero asynchronously, no response, next request completes normally.
